// File: rtl/key_switch_conditioner_if.sv
// Board-input / PIO-side bundle of the key and switch conditioner.
// master drives the raw pins, slave is the conditioner.
interface key_switch_conditioner_if #(
  parameter int SW_WIDTH = 8
);
  logic                key_n_in;
  logic [SW_WIDTH-1:0] sw_in;
  logic                accumulate_n_out;
  logic                accumulate_pulse;
  logic [SW_WIDTH-1:0] sw_out;
  logic                sw_changed;
  logic [7:0]          press_count;

  modport master (
    output key_n_in,
    output sw_in,
    input  accumulate_n_out,
    input  accumulate_pulse,
    input  sw_out,
    input  sw_changed,
    input  press_count
  );

  modport slave (
    input  key_n_in,
    input  sw_in,
    output accumulate_n_out,
    output accumulate_pulse,
    output sw_out,
    output sw_changed,
    output press_count
  );
endinterface

// File: rtl/key_switch_conditioner.sv
// Synchronizes/debounces KEY[1] and synchronizes SW[] for the Nios II PIOs.
// Define SW_DEBOUNCE_EN to also debounce the switch word as one vector.
module key_switch_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SW_WIDTH        = 8
) (
  input  logic clk,
  input  logic reset_n,
  key_switch_conditioner_if.slave io
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } key_state_t;

  logic                key_s1;
  logic                key_s2;
  logic [SW_WIDTH-1:0] sw_s1;
  logic [SW_WIDTH-1:0] sw_s2;

  key_state_t          state;
  logic [CW-1:0]       key_cnt;
  logic                acc_n;
  logic                acc_pulse;
  logic [7:0]          presses;

  logic [SW_WIDTH-1:0] sw_q;
  logic                sw_chg;

  // Key idles released (1); switches idle low.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      key_s1 <= io.key_n_in;
      key_s2 <= key_s1;
      sw_s1  <= io.sw_in;
      sw_s2  <= sw_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= RELEASED;
      key_cnt   <= '0;
      acc_n     <= 1'b1;
      acc_pulse <= 1'b0;
      presses   <= '0;
    end else begin
      acc_pulse <= 1'b0;
      unique case (state)
        RELEASED: begin
          if (!key_s2) begin
            state   <= WAIT_PRESS;
            key_cnt <= '0;
          end
        end
        WAIT_PRESS: begin
          if (key_s2) begin
            state   <= RELEASED;
            key_cnt <= '0;
          end else if (key_cnt == CNT_MAX) begin
            state     <= PRESSED;
            key_cnt   <= '0;
            acc_n     <= 1'b0;
            acc_pulse <= 1'b1;
            presses   <= presses + 8'd1;
          end else begin
            key_cnt <= key_cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (key_s2) begin
            state   <= WAIT_RELEASE;
            key_cnt <= '0;
          end
        end
        WAIT_RELEASE: begin
          if (!key_s2) begin
            state   <= PRESSED;
            key_cnt <= '0;
          end else if (key_cnt == CNT_MAX) begin
            state   <= RELEASED;
            key_cnt <= '0;
            acc_n   <= 1'b1;
          end else begin
            key_cnt <= key_cnt + 1'b1;
          end
        end
        default: begin
          state   <= RELEASED;
          key_cnt <= '0;
        end
      endcase
    end
  end

`ifdef SW_DEBOUNCE_EN
  logic [SW_WIDTH-1:0] sw_prev;
  logic [CW-1:0]       sw_cnt;

  // Any bit moving restarts the shared stability count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sw_prev <= '0;
      sw_cnt  <= '0;
      sw_q    <= '0;
      sw_chg  <= 1'b0;
    end else begin
      sw_prev <= sw_s2;
      sw_chg  <= 1'b0;
      if (sw_s2 != sw_prev) begin
        sw_cnt <= '0;
      end else if (sw_cnt != CNT_MAX) begin
        sw_cnt <= sw_cnt + 1'b1;
      end else if (sw_s2 != sw_q) begin
        sw_q   <= sw_s2;
        sw_chg <= 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sw_q   <= '0;
      sw_chg <= 1'b0;
    end else begin
      sw_q   <= sw_s2;
      sw_chg <= (sw_s2 != sw_q);
    end
  end
`endif

  assign io.accumulate_n_out = acc_n;
  assign io.accumulate_pulse = acc_pulse;
  assign io.press_count      = presses;
  assign io.sw_out           = sw_q;
  assign io.sw_changed       = sw_chg;

endmodule

// File: tb/tb_key_switch_conditioner.sv
// Randomized bench for key_switch_conditioner against a sample-history model.
// Works with SW_DEBOUNCE_EN defined or undefined.
module tb_key_switch_conditioner;
  localparam int D  = 16;
  localparam int NE = 40000;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  key_switch_conditioner_if #(.SW_WIDTH(8)) io ();

  key_switch_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .SW_WIDTH       (8)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .io     (io)
  );

  int n_vec = 0;
  int n_err = 0;
  int e;

  bit       kh [NE];
  bit [7:0] sh [NE];

  bit       m_acc_n;
  bit       m_pulse;
  bit [7:0] m_cnt;
  bit [7:0] m_sw;
  bit       m_chg;

  int   dut_pulses = 0;
  int   dut_chg    = 0;
  int   pulse_e    = 0;
  int   swchg_e    = 0;
  int   fall_e     = 0;
  logic prev_acc   = 1'b1;

  int       k, p0, c0, kr, sr;
  bit       kv;
  bit [7:0] sv;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0h, want %0h", tag, e, got, exp);
    end
  endtask

  // A level is accepted once the last D+1 samples that have crossed
  // the 2-FF synchronizer all disagree with the current level.
  task automatic model(input bit rn);
    bit       hit;
    bit [7:0] v;
    m_pulse = 1'b0;
    m_chg   = 1'b0;
    if (!rn) begin
      m_acc_n = 1'b1;
      m_cnt   = 8'd0;
      m_sw    = 8'd0;
      kh[e-1] = 1'b1;
      sh[e-1] = 8'd0;
    end else begin
      hit = 1'b1;
      for (int i = e - D - 2; i <= e - 2; i++)
        if (kh[i] == m_acc_n) hit = 1'b0;
      if (hit) begin
        m_acc_n = !m_acc_n;
        if (!m_acc_n) begin
          m_pulse = 1'b1;
          m_cnt   = m_cnt + 8'd1;
        end
      end
`ifdef SW_DEBOUNCE_EN
      v   = sh[e-2];
      hit = (v != m_sw);
      for (int i = e - D - 2; i <= e - 2; i++)
        if (sh[i] != v) hit = 1'b0;
      if (hit) begin
        m_sw  = v;
        m_chg = 1'b1;
      end
`else
      m_chg = (sh[e-2] != m_sw);
      m_sw  = sh[e-2];
`endif
    end
  endtask

  task automatic step(input bit rn, input bit key, input bit [7:0] sw);
    reset_n      = rn;
    io.key_n_in  = key;
    io.sw_in     = sw;
    @(posedge clk);
    e++;
    if (e >= NE) begin
      $display("FAIL budget: edge %0d reached limit %0d", e, NE);
      $fatal(1);
    end
    kh[e] = rn ? key : 1'b1;
    sh[e] = rn ? sw : 8'h00;
    model(rn);
    #1;
    chk("acc_n", io.accumulate_n_out, m_acc_n);
    chk("pulse", io.accumulate_pulse, m_pulse);
    chk("count", io.press_count, m_cnt);
    chk("sw_out", io.sw_out, m_sw);
    chk("sw_chg", io.sw_changed, m_chg);
    if (io.accumulate_pulse === 1'b1) begin
      dut_pulses++;
      pulse_e = e;
    end
    if (io.sw_changed === 1'b1) begin
      dut_chg++;
      swchg_e = e;
    end
    if (prev_acc === 1'b1 && io.accumulate_n_out === 1'b0) fall_e = e;
    prev_acc = io.accumulate_n_out;
    @(negedge clk);
  endtask

  initial begin
    io.key_n_in = 1'b1;
    io.sw_in    = 8'h00;
    e = D + 3;
    for (int i = 0; i <= D + 3; i++) begin
      kh[i] = 1'b1;
      sh[i] = 8'h00;
    end
    m_acc_n = 1'b1;
    m_pulse = 1'b0;
    m_cnt   = 8'd0;
    m_sw    = 8'd0;
    m_chg   = 1'b0;
    @(negedge clk);

    repeat (3) step(1'b0, 1'b0, 8'hFF);
    chk("rst_acc", io.accumulate_n_out, 1);
    chk("rst_sw", io.sw_out, 0);
    repeat (5) step(1'b1, 1'b1, 8'h00);

    p0 = dut_pulses;
    k  = e + 1;
    repeat (40) step(1'b1, 1'b0, 8'h00);
    chk("press_lat", fall_e - k, D + 2);
    chk("press_pulses", dut_pulses - p0, 1);
    chk("press_cnt", io.press_count, 1);
    repeat (40) step(1'b1, 1'b1, 8'h00);

    p0 = dut_pulses;
    for (int i = 0; i < 12; i++)
      repeat (5) step(1'b1, i[0], 8'h00);
    chk("bounce_quiet", dut_pulses - p0, 0);
    chk("bounce_level", io.accumulate_n_out, 1);
    k = e + 1;
    repeat (40) step(1'b1, 1'b0, 8'h00);
    chk("bounce_lat", fall_e - k, D + 2);
    chk("bounce_pulses", dut_pulses - p0, 1);
    repeat (40) step(1'b1, 1'b1, 8'h00);

    repeat (2) step(1'b0, 1'b1, 8'h00);
    p0 = dut_pulses;
    for (int i = 0; i < 256; i++) begin
      sv = 8'($urandom);
      repeat (D + 3 + $urandom_range(0, 4)) step(1'b1, 1'b0, sv);
      repeat (D + 3 + $urandom_range(0, 4)) step(1'b1, 1'b1, sv);
    end
    chk("wrap_pulses", dut_pulses - p0, 256);
    chk("wrap_cnt", io.press_count, 0);
    chk("wrap_rel", io.accumulate_n_out, 1);

    repeat (D + 4) step(1'b1, 1'b1, 8'h00);
    c0 = dut_chg;
    k  = e + 1;
    repeat (30) step(1'b1, 1'b1, 8'hA5);
`ifdef SW_DEBOUNCE_EN
    chk("sw_lat", swchg_e - k, D + 2);
`else
    chk("sw_lat", swchg_e - k, 2);
`endif
    chk("sw_step_chg", dut_chg - c0, 1);
    chk("sw_step_val", io.sw_out, 8'hA5);

    repeat (D + 4) step(1'b1, 1'b1, 8'h00);
    c0 = dut_chg;
    repeat (10) step(1'b1, 1'b1, 8'h3C);
    repeat (D + 4) step(1'b1, 1'b1, 8'h00);
    chk("glitch_val", io.sw_out, 8'h00);
`ifdef SW_DEBOUNCE_EN
    chk("glitch_chg", dut_chg - c0, 0);
`endif

    repeat (D + 4) step(1'b1, 1'b1, 8'h00);
    p0 = dut_pulses;
    c0 = dut_chg;
    repeat (30) step(1'b1, 1'b0, 8'h01);
    chk("simul_pulse", dut_pulses - p0, 1);
    chk("simul_chg", dut_chg - c0, 1);
`ifdef SW_DEBOUNCE_EN
    chk("simul_same", swchg_e, pulse_e);
`endif
    repeat (30) step(1'b1, 1'b1, 8'h01);

    kr = 0;
    sr = 0;
    kv = 1'b1;
    sv = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if (kr == 0) begin
        kv = !kv;
        kr = $urandom_range(1, 2 * D + 4);
      end
      if (sr == 0) begin
        sv = 8'($urandom);
        sr = $urandom_range(1, 2 * D);
      end
      kr--;
      sr--;
      step((i % 997) != 500, kv, sv);
    end

    step(1'b0, 1'b0, 8'hFF);
    chk("midrst_acc", io.accumulate_n_out, 1);
    chk("midrst_cnt", io.press_count, 0);
    repeat (D + 4) step(1'b1, 1'b1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
